neuron_seq: RTL and testbench

Sequencer that computes one neuron output, the dot product of `len` input/weight pairs followed by an optional threshold activation, by time-multiplexing a single shared ALU execution unit. It sits between the operand stream (input/weight memory readout) and the ALU: it drives the ALU control code and both sources, and captures the ALU result each cycle. It is the first clocked block around the combinational execution unit.

---
 rtl/nn_pkg.sv | 17 +
 rtl/neuron_seq_cnt.sv | 27 ++
 rtl/neuron_seq.sv | 139 +++++++++++++
 tb/tb_neuron_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron sequencer and the external ALU.
package nn_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ACC,
        ACT,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_seq_cnt.sv
// Loadable down-counter with zero flag, tracks the remaining input/weight pairs.
module neuron_seq_cnt #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] load_val,
    output logic             zero
);

    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/neuron_seq.sv
// Time-multiplexes one external ALU to compute a neuron dot product and optional
// threshold activation. Define NEURON_SEQ_ACT_EN to include the activation step.
module neuron_seq
    import nn_pkg::*;
#(
    parameter int unsigned nBits = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [nBits-1:0] threshold,
    input  logic             in_valid,
    input  logic [nBits-1:0] in_x,
    input  logic [nBits-1:0] in_w,
    output logic             in_ready,
    output logic [2:0]       alu_ctrl,
    output logic [nBits-1:0] alu_a,
    output logic [nBits-1:0] alu_b,
    input  logic [nBits-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [nBits-1:0] result
);

`ifdef NEURON_SEQ_ACT_EN
    localparam state_t POST_ACC = ACT;
    logic [nBits-1:0] thr_q;
`else
    localparam state_t POST_ACC = DONE;
    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [nBits-1:0] acc;
    logic [nBits-1:0] prod;
    logic             cnt_zero;
    logic             accept;
    logic             consume;

    assign accept  = (state == IDLE) && start;
    assign consume = (state == MUL) && in_valid;

    neuron_seq_cnt #(.LEN_W(LEN_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .dec      (consume),
        .load_val (len),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len == '0) ? POST_ACC : MUL;
            MUL:  if (in_valid) state_nxt = ACC;
            ACC:  state_nxt = cnt_zero ? POST_ACC : MUL;
            ACT:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive and handshake are decoded from state alone
    always_comb begin
        in_ready = 1'b0;
        alu_ctrl = ALU_NOP;
        alu_a    = '0;
        alu_b    = '0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            MUL: begin
                in_ready = 1'b1;
                alu_ctrl = ALU_MUL;
                alu_a    = in_x;
                alu_b    = in_w;
            end
            ACC: begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc;
                alu_b    = prod;
            end
`ifdef NEURON_SEQ_ACT_EN
            ACT: begin
                alu_ctrl = ALU_SLT;
                alu_a    = acc;
                alu_b    = thr_q;
            end
`endif
            DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef NEURON_SEQ_ACT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_q <= '0;
        end else if (accept) begin
            thr_q <= threshold;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            prod   <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                acc    <= '0;
                result <= '0;
            end
            if (consume) prod <= alu_result;
            if (state == ACC) acc <= alu_result;
`ifdef NEURON_SEQ_ACT_EN
            // SLT yields 1 when acc >= threshold
            if (state == ACT) result <= nBits'(alu_result[0]);
`else
            if ((state == ACC) && cnt_zero) result <= alu_result;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq with a behavioural model of the shared ALU.
module tb_neuron_seq;

`ifdef NEURON_SEQ_ACT_EN
    localparam bit ACT = 1'b1;
`else
    localparam bit ACT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] threshold;
    logic        in_valid;
    logic [31:0] in_x;
    logic [31:0] in_w;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    neuron_seq #(.nBits(32), .LEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (len),
        .threshold  (threshold),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_w       (in_w),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Reference ALU: unsigned, wrapping; SLT gives 0 when a<b, else 1
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a * alu_b;
            3'b010:  alu_result = (alu_a < alu_b) ? 32'd0 : 32'd1;
            default: alu_result = 32'd0;
        endcase
    end

    typedef struct {
        int unsigned     vlen;
        logic [31:0]     thr;
        logic [3:0][31:0] x;
        logic [3:0][31:0] w;
        int              stall_idx;
        int              stall_n;
        logic [31:0]     exp_res;
        int              exp_cyc;
    } vec_t;

    function automatic vec_t mk(int unsigned l, logic [31:0] t, logic [127:0] xs,
                                logic [127:0] ws, int si, int sn,
                                logic [31:0] er, int ec);
        vec_t v;
        v.vlen = l; v.thr = t; v.x = xs; v.w = ws;
        v.stall_idx = si; v.stall_n = sn; v.exp_res = er; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd7);
        chk({tag, " alu_ab"}, alu_a | alu_b, 32'd0);
        chk({tag, " result"}, result, 32'd0);
    endtask

    // Runs one job; cycle count is the number of edges from the start edge
    // up to and including the edge that raises done.
    task automatic run_job(input vec_t v, output logic [31:0] res, output int cyc,
                           output bit hs_ok, output bit tail_ok);
        int idx   = 0;
        int stall = 0;
        bit seen  = 1'b0;
        bit prev_stall = 1'b0;
        hs_ok = 1'b1; tail_ok = 1'b0; res = 'x; cyc = -1;
        @(negedge clk);
        start = 1'b1; len = 8'(v.vlen); threshold = v.thr;
        @(posedge clk);
        cyc = 1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall && !in_ready) hs_ok = 1'b0;
            if (in_ready && alu_ctrl != 3'b001) hs_ok = 1'b0;
            prev_stall = 1'b0;
            if (done) begin
                seen = 1'b1;
                res  = result;
                if (idx != int'(v.vlen)) hs_ok = 1'b0;
            end else begin
                if (in_ready && idx == v.stall_idx && stall < v.stall_n) begin
                    in_valid = 1'b0; stall++; prev_stall = 1'b1;
                end else if (in_ready && idx < 4) begin
                    in_valid = 1'b1; in_x = v.x[idx]; in_w = v.w[idx];
                end else begin
                    in_valid = 1'b1; in_x = 32'hDEAD_BEEF; in_w = 32'h0000_0F0F;
                end
                @(posedge clk);
                if (in_ready && in_valid) idx++;
                cyc++;
            end
        end
        if (!seen) cyc = -1;
        in_valid = 1'b0;
        @(negedge clk);
        tail_ok = !done && !busy && (result === res);
    endtask

    vec_t        vecs[8];
    logic [31:0] r;
    int          c;
    bit          hs, tl;
    int          ndone;
    int          done_cyc;
    logic [31:0] done_res;

    initial begin
        reset_n = 1'b0; start = 1'b0; len = '0; threshold = '0;
        in_valid = 1'b0; in_x = '0; in_w = '0;
        #1;
        chk_reset_state("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        vecs[0] = mk(3, 32'd10, {32'd0, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd6, 32'd5, 32'd4},
                     9, 0, ACT ? 32'd1 : 32'd32, ACT ? 8 : 7);
        vecs[1] = mk(3, 32'd40, {32'd0, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd6, 32'd5, 32'd4},
                     9, 0, ACT ? 32'd0 : 32'd32, ACT ? 8 : 7);
        vecs[2] = mk(3, 32'd10, {32'd0, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd6, 32'd5, 32'd4},
                     1, 3, ACT ? 32'd1 : 32'd32, ACT ? 11 : 10);
        vecs[3] = mk(0, 32'd0, '0, '0, 9, 0, ACT ? 32'd1 : 32'd0, ACT ? 2 : 1);
        vecs[4] = mk(0, 32'd1, '0, '0, 9, 0, 32'd0, ACT ? 2 : 1);
        vecs[5] = mk(1, 32'd0, {96'd0, 32'h0001_0000}, {96'd0, 32'h0001_0000},
                     9, 0, ACT ? 32'd1 : 32'd0, ACT ? 4 : 3);
        vecs[6] = mk(2, 32'd5, {64'd0, 32'd2, 32'hFFFF_FFFF}, {64'd0, 32'd3, 32'd2},
                     9, 0, ACT ? 32'd0 : 32'd4, ACT ? 6 : 5);
        vecs[7] = mk(2, 32'd4, {64'd0, 32'd2, 32'hFFFF_FFFF}, {64'd0, 32'd3, 32'd2},
                     9, 0, ACT ? 32'd1 : 32'd4, ACT ? 6 : 5);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i], r, c, hs, tl);
            chk($sformatf("v%0d result", i), r, vecs[i].exp_res);
            chk($sformatf("v%0d latency", i), 32'(c), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d handshake", i), 32'(hs), 32'd1);
            chk($sformatf("v%0d done_pulse", i), 32'(tl), 32'd1);
        end

        // start pulsed mid-job is ignored; exactly one done
        @(negedge clk);
        in_valid = 1'b1; in_x = 32'd2; in_w = 32'd3;
        start = 1'b1; len = 8'd3; threshold = 32'd10;
        @(posedge clk);
        ndone = 0; done_cyc = -1; done_res = 'x;
        for (int cy = 1; cy <= 30; cy++) begin
            @(negedge clk);
            start = (cy == 3);
            if (cy == 3) len = 8'd1;
            if (done) begin
                ndone++; done_cyc = cy; done_res = result;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("ign done_count", 32'(ndone), 32'd1);
        chk("ign latency", 32'(done_cyc), ACT ? 32'd8 : 32'd7);
        chk("ign result", done_res, ACT ? 32'd1 : 32'd18);

        // asynchronous reset in cycle 4 aborts the job
        @(negedge clk);
        in_valid = 1'b1; start = 1'b1; len = 8'd3; threshold = 32'd10;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_state("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int cy = 0; cy < 20; cy++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        in_valid = 1'b0;
        chk("abort no_done", 32'(ndone), 32'd0);
        chk("abort idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
